// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, reset PC, NOP encoding,
// fetch-entry layout and the fetch FSM state encoding.
package cpu_pkg;
    localparam int          XLEN     = 32;
    localparam int          ILEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: circular buffer of DEPTH entries with a separate count,
// synchronous flush, and same-cycle push/pop at both empty and full.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = cpu_pkg::fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 din,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // A pop frees the slot first, so a push into a full FIFO is legal alongside it.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != (PW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: one-outstanding imem handshake, prefetch FIFO,
// redirect flush. Optional macro IF_BYPASS_EN forwards a response straight to decode.
module if_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [ILEN-1:0]        imem_rdata,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   inst_valid,
    output logic [ILEN-1:0]        inst_out,
    output logic [XLEN-1:0]        inst_pc,
    input  logic                   inst_ready,
    output logic [$clog2(DEPTH):0] fifo_count
);
    import cpu_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } entry_t;

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] tag_pc;
    logic            grant;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            bypass;
    entry_t          head;
    logic            unused_pc_lsb;

    assign unused_pc_lsb = &{1'b0, redirect_pc[1:0]};
    assign fifo_empty    = (fifo_count == '0);
    assign grant         = imem_req & imem_ready;
    assign imem_addr     = fetch_pc;

`ifdef IF_BYPASS_EN
    assign bypass = (state == ST_WAIT) & imem_rvalid & ~redirect & fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_RUN;
        else        state <= state_nxt;
    end

    // A response arriving with a redirect is simply discarded, landing in RUN.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN:  if (grant) state_nxt = ST_WAIT;
            ST_WAIT: if (imem_rvalid) state_nxt = ST_RUN;
                     else if (redirect) state_nxt = ST_DROP;
            ST_DROP: if (imem_rvalid) state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    // Requesting only below DEPTH reserves the slot the response will occupy.
    always_comb begin
        imem_req = 1'b0;
        push     = 1'b0;
        unique case (state)
            ST_RUN:  imem_req = reset & ~redirect & (fifo_count < CW'(DEPTH));
            ST_WAIT: push = imem_rvalid & ~redirect & ~(bypass & inst_ready);
            default: ;
        endcase
    end

    assign inst_valid = ~redirect & (~fifo_empty | bypass);
    assign inst_out   = ~fifo_empty ? head.inst : (bypass ? imem_rdata : '0);
    assign inst_pc    = ~fifo_empty ? head.pc   : (bypass ? tag_pc     : '0);
    assign pop        = inst_valid & inst_ready & ~fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            tag_pc   <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (grant) begin
            fetch_pc <= fetch_pc + XLEN'(4);
            tag_pc   <= fetch_pc;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push  (push),
        .din   (entry_t'{pc: tag_pc, inst: imem_rdata}),
        .pop   (pop),
        .head  (head),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: decode must see program-order {pc, inst}
// from each restart point; fetch addresses must be sequential from the same point.
module tb_if_fetch_unit;
    localparam int          XLEN     = 32;
    localparam int          ILEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .fifo_count(fifo_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_next;
    logic [31:0] fetch_exp;
    int          n_vec = 0;
    int          n_err = 0;
    int          pops = 0;
    int          grants = 0;
    bit          pending = 0;
    logic [31:0] paddr;
    int          cnt = 0;
    int          mem_lat = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_restart(input logic [31:0] pc);
        exp_q.delete();
        exp_next  = {pc[31:2], 2'b00};
        fetch_exp = {pc[31:2], 2'b00};
    endtask

    task automatic refill();
        exp_t e;
        while (exp_q.size() < 8) begin
            e.pc   = exp_next;
            e.inst = mem_word(exp_next);
            exp_q.push_back(e);
            exp_next = exp_next + 32'd4;
        end
    endtask

    // One cycle of stimulus plus the memory model (one outstanding, fixed latency).
    task automatic step(input bit ir, input bit dr, input bit rd, input logic [31:0] rpc);
        @(negedge clk);
        imem_ready  = ir;
        inst_ready  = dr;
        redirect    = rd;
        redirect_pc = rpc;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pending) begin
            if (cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(paddr);
                pending     = 0;
            end else begin
                cnt--;
            end
        end
        #1;
        if (rd) begin
            model_restart(rpc);
            chk("redirect_valid_low", {63'd0, inst_valid}, 64'd0);
        end
        if (imem_req && imem_ready) begin
            pending = 1;
            paddr   = imem_addr;
            cnt     = mem_lat - 1;
            grants++;
        end
        refill();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                chk("count_bound", {63'd0, fifo_count <= 3'(DEPTH)}, 64'd1);
                if (imem_req && imem_ready) begin
                    chk("fetch_addr", {32'd0, imem_addr}, {32'd0, fetch_exp});
                    fetch_exp = fetch_exp + 32'd4;
                end
                if (inst_valid && inst_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL pop_unexpected: got pc %0h expected no entry", inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("inst_pc", {32'd0, inst_pc}, {32'd0, e.pc});
                        chk("inst_out", {32'd0, inst_out}, {32'd0, e.inst});
                        pops++;
                    end
                end
            end
        end
    end

    initial begin : main
        int  g0;
        int  p0;
        bit  ok;
        reset = 1'b0; imem_ready = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
        redirect_pc = '0; imem_rvalid = 1'b0; imem_rdata = '0;
        model_restart(RESET_PC);
        refill();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_count", {61'd0, fifo_count}, 64'd0);
        chk("rst_inst_out", {32'd0, inst_out}, 64'd0);
        chk("rst_inst_pc", {32'd0, inst_pc}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("first_addr", {32'd0, imem_addr}, {32'd0, RESET_PC});
        chk("first_req", {63'd0, imem_req}, 64'd1);

        // Straight-line fetch, latency 1
        repeat (12) step(1, 1, 0, '0);
        chk("basic_pops_ge3", {63'd0, pops >= 3}, 64'd1);

        // Backpressure fills the FIFO: exactly DEPTH grants, then one more per pop
        step(0, 0, 1, 32'h200);
        g0 = grants;
        repeat (20) step(1, 0, 0, '0);
        chk("full_grants", 64'(grants - g0), 64'(DEPTH));
        chk("full_count", {61'd0, fifo_count}, 64'(DEPTH));
        chk("full_req", {63'd0, imem_req}, 64'd0);
        step(1, 1, 0, '0);
        repeat (6) step(1, 0, 0, '0);
        chk("refill_grants", 64'(grants - g0), 64'(DEPTH + 1));

        // Redirect while a fetch is outstanding: its response must be dropped
        step(0, 0, 1, 32'h300);
        mem_lat = 3;
        g0 = grants;
        step(1, 0, 0, '0);
        chk("wait_grant", 64'(grants - g0), 64'd1);
        step(0, 0, 1, 32'h103);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        chk("drop_rvalid_seen", {63'd0, imem_rvalid}, 64'd1);
        step(0, 0, 0, '0);
        chk("drop_count", {61'd0, fifo_count}, 64'd0);
        chk("drop_addr", {32'd0, imem_addr}, 64'h100);
        chk("drop_req", {63'd0, imem_req}, 64'd1);
        mem_lat = 1;
        p0 = pops;
        repeat (6) step(1, 1, 0, '0);
        chk("after_drop_pops", {63'd0, pops > p0}, 64'd1);

        // Redirect with rvalid and inst_ready in the same cycle, FIFO holding two
        step(0, 0, 1, 32'h400);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step(1, 0, 0, '0);
            if (fifo_count == 3'd2 && pending && cnt == 0) ok = 1;
        end
        chk("two_entry_setup", {63'd0, ok}, 64'd1);
        p0 = pops;
        step(1, 1, 1, 32'h480);
        chk("combo_rvalid", {63'd0, imem_rvalid}, 64'd1);
        step(0, 0, 0, '0);
        chk("combo_count", {61'd0, fifo_count}, 64'd0);
        chk("combo_no_pop", 64'(pops - p0), 64'd0);
        chk("combo_run_req", {63'd0, imem_req}, 64'd1);
        chk("combo_addr", {32'd0, imem_addr}, 64'h480);

        // PC wrap modulo 2^32
        step(0, 0, 1, 32'hFFFF_FFFE);
        repeat (10) step(1, 1, 0, '0);

        // Reset mid-WAIT, then a stale response after release
        mem_lat = 3;
        step(0, 0, 1, 32'h500);
        step(1, 0, 0, '0);
        chk("pre_reset_grant", {63'd0, pending}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_req", {63'd0, imem_req}, 64'd0);
        chk("mid_rst_count", {61'd0, fifo_count}, 64'd0);
        chk("mid_rst_valid", {63'd0, inst_valid}, 64'd0);
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_restart(RESET_PC);
        refill();
        cnt = 0;
        mem_lat = 1;
        step(0, 0, 0, '0);
        chk("stale_rvalid_seen", {63'd0, imem_rvalid}, 64'd1);
        step(0, 0, 0, '0);
        chk("stale_count", {61'd0, fifo_count}, 64'd0);
        chk("stale_valid", {63'd0, inst_valid}, 64'd0);
        chk("stale_addr", {32'd0, imem_addr}, {32'd0, RESET_PC});

        // First-response latency (bypass forwards in the rvalid cycle)
        step(0, 0, 1, 32'h600);
        step(1, 1, 0, '0);
        step(1, 1, 0, '0);
`ifdef IF_BYPASS_EN
        chk("byp_valid_same_cycle", {63'd0, inst_valid}, 64'd1);
        chk("byp_pc", {32'd0, inst_pc}, 64'h600);
        step(0, 1, 0, '0);
        chk("byp_count", {61'd0, fifo_count}, 64'd0);
`else
        chk("lat_valid_low", {63'd0, inst_valid}, 64'd0);
        step(0, 1, 0, '0);
        chk("lat_valid_next", {63'd0, inst_valid}, 64'd1);
        chk("lat_count", {61'd0, fifo_count}, 64'd1);
`endif

        // Randomised traffic
        repeat (3000) begin
            mem_lat = $urandom_range(1, 3);
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 3, $urandom);
        end
        repeat (8) step(0, 1, 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation (pipelined) core. It replaces the direct PC→inst_in path of the single-cycle CPU.
- Generates the fetch PC and drives a request/grant/response handshake to instruction memory, with one outstanding request.
- Buffers fetched {pc, inst} pairs in a DEPTH-entry prefetch FIFO.
- Presents them to decode with a valid/ready handshake.
- Supports pipeline redirect (branch/jump/interrupt), which flushes the FIFO and in-flight fetches.

Parameters:
XLEN, 32, PC/address width
ILEN, 32, instruction width
DEPTH, 4, prefetch FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address; word aligned
imem_ready  in  1  memory accepts the request this cycle (grant = imem_req & imem_ready)
imem_rvalid  in  1  response data valid; at least 1 cycle after grant
imem_rdata  in  ILEN  fetched instruction
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (forced 0)
inst_valid  out  1  FIFO head valid toward decode
inst_out  out  ILEN  head instruction
inst_pc  out  XLEN  PC of head instruction
inst_ready  in  1  decode consumes head (pop = inst_valid & inst_ready)
fifo_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
Reset values:
- fetch_pc = RESET_PC; state = RUN; FIFO empty.
- imem_req = 0 while reset is asserted; inst_valid = 0; fifo_count = 0; inst_out = 0; inst_pc = 0.

FSM states: RUN (no outstanding), WAIT (one outstanding, keep), DROP (one outstanding, discard).

RUN:
- imem_req = (fifo_count < DEPTH) & ~redirect. The slot is reserved at grant, so a response never overflows the FIFO.
- imem_addr = fetch_pc.
- On grant → WAIT; fetch_pc += 4; the granted PC is latched as the tag for the response.

WAIT:
- imem_req = 0.
- On imem_rvalid: push {tag_pc, imem_rdata}; → RUN. A new request may be issued the following cycle.

DROP:
- imem_req = 0.
- On imem_rvalid: data discarded; → RUN.

Redirect (highest priority, any state):
- FIFO flushed; fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
- inst_valid forced 0 in the redirect cycle; a same-cycle pop has no effect.
- State transitions:
  - WAIT → DROP, unless imem_rvalid arrives in the same cycle; then that data is discarded and the next state is RUN.
  - DROP → DROP, or → RUN if imem_rvalid arrives in the same cycle.
  - RUN → RUN; any ungranted request is withdrawn.
- Requests resume the cycle after redirect, at the new PC.

Other rules:
- Push and pop in the same cycle: count unchanged; legal at full and empty. The pop is applied first for head selection.
- Latency without bypass: grant at cycle t, rvalid at t+k → inst_valid at t+k+1.
- fetch_pc wraps modulo 2^XLEN with no flag.
- Reset mid-fetch: state, FIFO and PC clear immediately. A late rvalid after reset release is ignored because state is RUN.
- FIFO storage is a circular buffer with $clog2(DEPTH)-bit pointers and a separate count.

Optional Feature:
IF_BYPASS_EN
- Defined: when the FIFO is empty, imem_rvalid is in WAIT and there is no redirect, the response is driven combinationally onto inst_valid/inst_out/inst_pc.
  - If inst_ready is also 1, the entry is consumed without a push (zero-cycle buffering).
  - Otherwise it is pushed normally.
- Undefined: every response goes through the FIFO, giving 1 cycle minimum added latency.

Decomposition:
- Shared package cpu_pkg: XLEN, ILEN, RESET_PC default, NOP_INST = 32'h0000_0013, and the fetch-entry struct fetch_entry_t {pc, inst}.
- Fetch FSM state enum lives in cpu_pkg.
- One sub-module: fetch_fifo, a parametrised DEPTH x fetch_entry_t synchronous FIFO with flush, push, pop, count, head.

Test Plan:
- Release reset, imem_ready=1, rvalid 1 cycle after each grant, inst_ready=1 → imem_addr sequence 0x0, 0x4, 0x8; inst_pc at decode 0x0, 0x4, 0x8 in order; inst_out matches memory words.
- inst_ready=0, DEPTH=4 → exactly 4 grants, then imem_req stays 0 with fifo_count=4; raising inst_ready for one cycle → one further request issued.
- Redirect to 0x103 while in WAIT, rvalid 2 cycles later with 0xDEADBEEF → that response dropped, FIFO empty, next imem_addr = 0x100, first delivered inst_pc = 0x100.
- Redirect in the same cycle as imem_rvalid and inst_ready with FIFO holding 2 entries → fifo_count=0 next cycle, no pop observed, state RUN.
- Assert reset low mid-WAIT, then release → imem_addr = RESET_PC, inst_valid=0, a stale rvalid causes no push.
- IF_BYPASS_EN defined, FIFO empty, inst_ready=1 → inst_valid high in the same cycle as imem_rvalid, fifo_count stays 0.
